// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs for pipeline_ctrl.
// The slave modport is the controller's view; the master modport is the pipeline/driver view.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             branch_resolved;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_enable;
    logic             if_id_enable;
    logic             id_ex_enable;
    logic             ex_mem_enable;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read,
               branch_resolved, branch_taken, dmem_req, dmem_ready,
        output pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
               if_id_flush, id_ex_flush, state, stall_cycles, flush_events
    );

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read,
               branch_resolved, branch_taken, dmem_req, dmem_ready,
        input  pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
               if_id_flush, id_ex_flush, state, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stalls, branch redirect
// flushes and load-use stalls, with saturating stall/flush performance counters.
// Handshake note: dmem_req/dmem_ready form a request/ready pair; a request with
// ready low freezes every pipeline register until ready rises.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    localparam logic [1:0] RUN        = 2'b00;
    localparam logic [1:0] LOAD_STALL = 2'b01;
    localparam logic [1:0] FLUSH      = 2'b10;
    localparam logic [1:0] MEM_WAIT   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic             mem_stall, redirect, load_use, uses_rs1, uses_rs2;

    // Hazard conditions decoded from the ID/EX/MEM stage inputs.
    always_comb begin
        mem_stall = bus.dmem_req && !bus.dmem_ready;
        redirect  = bus.branch_resolved && bus.branch_taken;
        uses_rs1  = !((bus.id_opcode == 7'b0110111) || (bus.id_opcode == 7'b0010111) ||
                      (bus.id_opcode == 7'b1101111));
        uses_rs2  = (bus.id_opcode == 7'b0110011) || (bus.id_opcode == 7'b0100011) ||
                    (bus.id_opcode == 7'b1100011);
        load_use  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                     (uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    end

    // Output/next-state decode; mem_stall outranks redirect, which outranks load_use.
    always_comb begin
        bus.pc_enable     = 1'b1;
        bus.if_id_enable  = 1'b1;
        bus.id_ex_enable  = 1'b1;
        bus.ex_mem_enable = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_flush   = 1'b0;
        state_d           = RUN;
        stall_inc         = 1'b0;
        flush_inc         = 1'b0;
        if (!rst) begin
            bus.pc_enable     = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.id_ex_enable  = 1'b0;
            bus.ex_mem_enable = 1'b0;
            bus.if_id_flush   = 1'b1;
            bus.id_ex_flush   = 1'b1;
        end else if (mem_stall) begin
            bus.pc_enable     = 1'b0;
            bus.if_id_enable  = 1'b0;
            bus.id_ex_enable  = 1'b0;
            bus.ex_mem_enable = 1'b0;
            state_d           = MEM_WAIT;
            stall_inc         = 1'b1;
        end else if ((state_q == RUN) || (state_q == MEM_WAIT)) begin
            // FLUSH and LOAD_STALL fall through to defaults: hazards masked for that one cycle.
            if (redirect) begin
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
                state_d         = FLUSH;
                flush_inc       = 1'b1;
            end else if (load_use) begin
                bus.pc_enable    = 1'b0;
                bus.if_id_enable = 1'b0;
                bus.id_ex_flush  = 1'b1;
                state_d          = LOAD_STALL;
                stall_inc        = 1'b1;
            end
        end
    end

    // State register and saturating counters; reset aborts any sequence without counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a vector table applied from RUN, then hand-written
// multi-cycle sequences (load-use, redirect, memory wait, saturation, reset).
module tb_pipeline_ctrl;
    localparam logic [1:0] RUN = 2'b00, LS = 2'b01, FL = 2'b10, MW = 2'b11;
    // Packed outputs: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
    localparam logic [5:0] O_DEF = 6'b111100;
    localparam logic [5:0] O_MEM = 6'b000000;
    localparam logic [5:0] O_RED = 6'b111111;
    localparam logic [5:0] O_LU  = 6'b001101;
    localparam logic [5:0] O_RST = 6'b000011;

    typedef struct {
        logic [6:0] opc;
        logic [4:0] rs1, rs2, rd;
        logic       mr, br, bt, dq, dr;
        logic [5:0] exp_o;
        logic [1:0] exp_s;
        logic       s_inc, f_inc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   stall_m, flush_m;
    logic [5:0] exp_q[$];
    vec_t vecs[$];

    pipeline_ctrl_if #(.CNT_W(16)) bus16 ();
    pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

    pipeline_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    pipeline_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.id_opcode       = bus16.id_opcode;
    assign bus4.id_rs1          = bus16.id_rs1;
    assign bus4.id_rs2          = bus16.id_rs2;
    assign bus4.ex_rd           = bus16.ex_rd;
    assign bus4.ex_mem_read     = bus16.ex_mem_read;
    assign bus4.branch_resolved = bus16.branch_resolved;
    assign bus4.branch_taken    = bus16.branch_taken;
    assign bus4.dmem_req        = bus16.dmem_req;
    assign bus4.dmem_ready      = bus16.dmem_ready;

    // Clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic mr, input logic br, input logic bt,
                                input logic dq, input logic dr, input logic [5:0] eo,
                                input logic [1:0] es, input logic si, input logic fi);
        vec_t v;
        v.opc = opc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr;
        v.br = br; v.bt = bt; v.dq = dq; v.dr = dr;
        v.exp_o = eo; v.exp_s = es; v.s_inc = si; v.f_inc = fi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus16.id_opcode       = v.opc;
        bus16.id_rs1          = v.rs1;
        bus16.id_rs2          = v.rs2;
        bus16.ex_rd           = v.rd;
        bus16.ex_mem_read     = v.mr;
        bus16.branch_resolved = v.br;
        bus16.branch_taken    = v.bt;
        bus16.dmem_req        = v.dq;
        bus16.dmem_ready      = v.dr;
    endtask

    task automatic drive_idle();
        drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
    endtask

    task automatic expect_out(input logic [5:0] e);
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the DUT's live outputs (called at negedge).
    task automatic check_out(input string name);
        logic [5:0] act, e;
        act = {bus16.pc_enable, bus16.if_id_enable, bus16.id_ex_enable, bus16.ex_mem_enable,
               bus16.if_id_flush, bus16.id_ex_flush};
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(name, {26'd0, act}, {26'd0, e});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        drive_idle();
        // Forced outputs while in reset, and clean state afterwards.
        expect_out(O_RST);
        @(negedge clk);
        check_out("rst_forced");
        do_reset();
        chk("rst_state", {30'd0, bus16.state}, {30'd0, RUN});
        chk("rst_stall", {16'd0, bus16.stall_cycles}, 32'd0);
        chk("rst_flush", {16'd0, bus16.flush_events}, 32'd0);

        // Vector table: each applied from RUN, then one idle cycle returns to RUN.
        vecs.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  LS,  1'b1, 1'b0));
        vecs.push_back(mk(7'b0000011, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  LS,  1'b1, 1'b0));
        vecs.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010111, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b1101111, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0100011, 5'd2, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  LS,  1'b1, 1'b0));
        vecs.push_back(mk(7'b1100011, 5'd2, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  LS,  1'b1, 1'b0));
        vecs.push_back(mk(7'b1100111, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  LS,  1'b1, 1'b0));
        vecs.push_back(mk(7'b0110011, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_RED, FL,  1'b0, 1'b1));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_RED, FL,  1'b0, 1'b1));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MEM, MW,  1'b1, 1'b0));
        vecs.push_back(mk(7'b0110011, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_MEM, MW,  1'b1, 1'b0));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_DEF, RUN, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF, RUN, 1'b0, 1'b0));

        stall_m = 0;
        flush_m = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            expect_out(vecs[i].exp_o);
            if (vecs[i].s_inc) stall_m++;
            if (vecs[i].f_inc) flush_m++;
            @(negedge clk);
            check_out($sformatf("vec%0d_out", i));
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, bus16.state}, {30'd0, vecs[i].exp_s});
            drive_idle();
            tick();
            chk($sformatf("vec%0d_back", i), {30'd0, bus16.state}, {30'd0, RUN});
        end
        chk("tbl_stall", {16'd0, bus16.stall_cycles}, stall_m);
        chk("tbl_flush", {16'd0, bus16.flush_events}, flush_m);

        // Load-use held for two cycles: second cycle is masked in LOAD_STALL.
        do_reset();
        drive(mk(7'b0110011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, LS, 1'b1, 1'b0));
        expect_out(O_LU);
        @(negedge clk);
        check_out("lu_c1");
        tick();
        chk("lu_state1", {30'd0, bus16.state}, {30'd0, LS});
        expect_out(O_DEF);
        @(negedge clk);
        check_out("lu_c2_masked");
        tick();
        chk("lu_state2", {30'd0, bus16.state}, {30'd0, RUN});
        chk("lu_stall", {16'd0, bus16.stall_cycles}, 32'd1);

        // Redirect held for two cycles: FLUSH lasts one cycle and masks the second.
        do_reset();
        drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_RED, FL, 1'b0, 1'b1));
        expect_out(O_RED);
        @(negedge clk);
        check_out("rd_c1");
        tick();
        chk("rd_state1", {30'd0, bus16.state}, {30'd0, FL});
        expect_out(O_DEF);
        @(negedge clk);
        check_out("rd_c2_masked");
        tick();
        chk("rd_state2", {30'd0, bus16.state}, {30'd0, RUN});
        chk("rd_flush", {16'd0, bus16.flush_events}, 32'd1);
        chk("rd_stall", {16'd0, bus16.stall_cycles}, 32'd0);

        // Memory wait of three cycles with a concurrent redirect, released into FLUSH.
        do_reset();
        drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_MEM, MW, 1'b1, 1'b0));
        for (int c = 0; c < 3; c++) begin
            expect_out(O_MEM);
            @(negedge clk);
            check_out($sformatf("mw_c%0d", c));
            tick();
            chk($sformatf("mw_state%0d", c), {30'd0, bus16.state}, {30'd0, MW});
        end
        bus16.dmem_ready = 1'b1;
        expect_out(O_RED);
        @(negedge clk);
        check_out("mw_release");
        tick();
        chk("mw_state_fl", {30'd0, bus16.state}, {30'd0, FL});
        drive_idle();
        tick();
        chk("mw_stall", {16'd0, bus16.stall_cycles}, 32'd3);
        chk("mw_flush", {16'd0, bus16.flush_events}, 32'd1);

        // Saturation: 20 memory-stall cycles on the 4-bit instance.
        do_reset();
        drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MEM, MW, 1'b1, 1'b0));
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 14) chk("sat_reach15", {28'd0, bus4.stall_cycles}, 32'd15);
        end
        chk("sat_hold15", {28'd0, bus4.stall_cycles}, 32'd15);
        chk("sat_wide20", {16'd0, bus16.stall_cycles}, 32'd20);

        // Reset mid-MEM_WAIT with the stall still requested: forced outputs, no count.
        rst = 1'b0;
        expect_out(O_RST);
        @(negedge clk);
        check_out("rmw_forced");
        tick();
        chk("rmw_state", {30'd0, bus16.state}, {30'd0, RUN});
        chk("rmw_stall", {16'd0, bus16.stall_cycles}, 32'd0);
        chk("rmw_stall4", {28'd0, bus4.stall_cycles}, 32'd0);
        rst = 1'b1;
        drive_idle();
        expect_out(O_DEF);
        @(negedge clk);
        check_out("rmw_after");
        chk("rmw_after_state", {30'd0, bus16.state}, {30'd0, RUN});

        // Reset on the edge that would have entered FLUSH: no flush counted.
        drive(mk(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_RED, FL, 1'b0, 1'b1));
        rst = 1'b0;
        tick();
        chk("rfl_state", {30'd0, bus16.state}, {30'd0, RUN});
        chk("rfl_flush", {16'd0, bus16.flush_events}, 32'd0);
        rst = 1'b1;
        drive_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
